seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit owns a DIV-cycle slot that opens with BLANK dark cycles to avoid ghosting.
module seg_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [6:0] firstSegment,
    input  logic [6:0] secondSegment,
    input  logic [6:0] thirdSegment,
    input  logic [6:0] fourthSegment,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       slot_start
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [6:0]       hold, hold_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic             slot_start_nxt;
    logic             blank_nxt;
    logic [6:0]       pattern_sel;

    // State register: outputs are registered from the same next values as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            hold       <= '0;
            seg        <= 7'b1111111;
            an         <= 4'b1111;
            slot_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            hold       <= hold_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            slot_start <= slot_start_nxt;
        end
    end

    always_comb begin
        pattern_sel = firstSegment;
        case (idx + 2'd1)
            2'd0: pattern_sel = firstSegment;
            2'd1: pattern_sel = secondSegment;
            2'd2: pattern_sel = thirdSegment;
            2'd3: pattern_sel = fourthSegment;
            default: pattern_sel = firstSegment;
        endcase
    end

    // Next state: IDLE -> RUN always opens with a fresh slot 0 without advancing cnt.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        hold_nxt  = hold;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            hold_nxt  = firstSegment;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            idx_nxt  = idx + 2'd1;
            hold_nxt = pattern_sel;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    generate
        if (BLANK == 0) begin : g_noblank
            assign blank_nxt = 1'b0;
        end else begin : g_blank
            assign blank_nxt = (cnt_nxt < CNT_W'(BLANK));
        end
    endgenerate

    always_comb begin
        slot_start_nxt = en && (cnt_nxt == '0);
        an_nxt         = 4'b1111;
        seg_nxt        = 7'b1111111;
        if (en && !blank_nxt) begin
            an_nxt  = ~(4'b1000 >> idx_nxt);
            seg_nxt = ~hold_nxt;
        end
    end

    assign digit_idx = idx;

endmodule
